nibble_mult_sequencer: RTL
==========================

Name: nibble_mult_sequencer

Overview:
- Multi-cycle unsigned multiplier controller built around one instance of the existing 4x4 combinational parallel_multiplier.
- Splits wide operands into 4-bit nibbles, feeds one nibble pair per cycle through the shared 4x4 array, and accumulates shifted partial products.
- Sits between an operand producer and a result consumer; valid/ready handshake on both sides.

Parameters:
- N_NIB, 2, nibbles per operand; operand width W = 4*N_NIB, product width 2W. Legal range 1..4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- in_a  input  W  multiplicand, unsigned
- in_b  input  W  multiplier, unsigned
- abort  input  1  synchronous cancel of current operation
- busy  output  1  high in MUL or DONE state
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- out_prod  output  2W  product A*B, unsigned

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: state=IDLE, in_ready=1, busy=0, out_valid=0, out_prod=0, internal accumulator, indices and operand registers=0. Reset asserted mid-operation discards the operation; no product is emitted.
- States: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 and abort=0 at an edge: latch in_a/in_b, clear acc, i=j=0, go to MUL.
  - abort=1 blocks acceptance.
- MUL:
  - in_ready=0.
  - Each cycle, drive the 4x4 multiplier with nibble a[4i+3:4i] and nibble b[4j+3:4j].
  - At the edge: acc += zero-extended 8-bit result << 4*(i+j), computed at 2W bits. No overflow is possible; any carry out of 2W is a design error.
  - Index order: j increments fastest; when j=N_NIB-1, set j=0 and increment i.
  - After the step with i=j=N_NIB-1, go to DONE.
  - This takes N_NIB^2 cycles in MUL.
- DONE:
  - out_valid=1; out_prod=acc, registered and stable while out_valid is high.
  - out_valid=1 and out_ready=1 at an edge: go to IDLE, out_valid=0.
  - out_prod holds its last value until the next DONE.
- Latency: operands accepted at edge k; out_valid high after edge k+N_NIB^2 (4 cycles for the default). Fixed, data-independent; no zero-skipping.
- Throughput: at most one product per N_NIB^2+2 cycles. in_ready rises the cycle after the output handshake; there is no overlap of accept and emit.
- abort:
  - From MUL or DONE: go to IDLE at the next edge and clear out_valid. The in-flight result is lost.
  - abort has priority over out_ready in the same cycle; the product is not counted as delivered.
  - abort in IDLE is a no-op apart from blocking acceptance.
- in_valid while in_ready=0 is ignored; operands are not queued.
- busy = (state != IDLE).
- Operand registers are not modified outside IDLE acceptance. in_a/in_b changing during MUL has no effect.
- Illegal state encodings recover to IDLE.

Test Plan:
- Reset then in_a=0xFF, in_b=0xFF, in_valid pulse, out_ready=1 -> in_ready low next cycle; out_valid high exactly 4 cycles after accept with out_prod=0xFE01; in_ready high one cycle after the handshake.
- Directed corner products: 0x00*0xAB=0x0000, 0x01*0x37=0x0037, 0x10*0x10=0x0100, 0xF0*0x0F=0x0E10 -> each product exact, latency 4 every time.
- Backpressure: 0x12*0x34 with out_ready=0 for 10 cycles -> out_valid and out_prod=0x03A8 held stable throughout; in_valid pulses during the stall are ignored; the handshake completes when out_ready rises.
- Abort on the 2nd MUL cycle of 0xAA*0x55 -> IDLE next edge, out_valid never rises; the next op 0x03*0x07 yields 0x0015 (no residue in acc).
- Abort and out_ready both high in DONE -> IDLE, out_valid=0; abort and in_valid both high in IDLE -> no accept, busy stays 0.
- rst_n asserted asynchronously mid-MUL -> all outputs return to reset values immediately; after release, 0xC8*0x64 yields 0x4E20; the N_NIB=1 build gives 0xF*0xF=0xE1 with latency 1.

Source files
------------

// File: rtl/nibble_mult_sequencer.sv
// Multi-cycle unsigned multiplier. Wide operands are split into 4-bit
// nibbles. Each cycle one nibble pair goes through a shared 4x4 array, and
// the shifted partial product is added into a 2W-bit accumulator.
//
// state | meaning
// IDLE  | ready for an operand pair
// MUL   | one nibble pair per cycle, N_NIB^2 cycles
// DONE  | product presented, waiting for the consumer

// Existing 4x4 combinational array multiplier.
module parallel_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module nibble_mult_sequencer #(
  parameter int N_NIB = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*N_NIB-1:0]   in_a,
  input  logic [4*N_NIB-1:0]   in_b,
  input  logic                 abort,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*N_NIB-1:0]   out_prod
);
  localparam int W  = 4 * N_NIB;
  localparam int PW = 2 * W;
  localparam int IW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [PW-1:0]   r_acc;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;
  logic            r_in_ready;
  logic            r_busy;
  logic            r_out_valid;
  logic [PW-1:0]   r_out_prod;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [7:0]      w_prod;
  logic [IW:0]     w_isum;
  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_acc_nxt;
  logic            w_last;

  // Nibble select, shift and accumulate for the current (i, j) step.
  assign w_a_nib   = 4'(r_a >> {r_i, 2'b00});
  assign w_b_nib   = 4'(r_b >> {r_j, 2'b00});
  assign w_isum    = {1'b0, r_i} + {1'b0, r_j};
  assign w_pp      = PW'(w_prod) << {w_isum, 2'b00};
  assign w_acc_nxt = r_acc + w_pp;
  assign w_last    = (r_i == LAST) && (r_j == LAST);

  parallel_multiplier u_mul (
    .a (w_a_nib),
    .b (w_b_nib),
    .p (w_prod)
  );

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_prod  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && !abort) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_acc      <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_state    <= S_MUL;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_MUL: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end else begin
            r_acc <= w_acc_nxt;
            if (r_j == LAST) begin
              r_j <= '0;
              r_i <= r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
            if (w_last) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_out_prod  <= w_acc_nxt;
            end
          end
        end
        S_DONE: begin
          // abort takes priority; either way the block returns to IDLE
          if (abort || out_ready) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_prod  = r_out_prod;

endmodule
